multicycle_control: RTL and testbench

- Parametrised successor to the single-cycle decoder: a multi-cycle RV32I control FSM.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Stalls on a memory ready handshake and counts retired instructions.
- Sits between the instruction register/memory interface and the shared datapath (ALU, register file, PC).

---
 rtl/multicycle_control.sv | 182 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch, decode, execute, memory, writeback with memory-ready stalls.
// Define MULTICYCLE_CONTROL_TRAP_EN to trap on unknown opcodes; otherwise they are skipped.
module multicycle_control #(
  parameter int IW     = 32,
  parameter int ALUOPW = 3,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [IW-1:0]     instruction,
  input  logic              memready,
  output logic              pcwrite,
  output logic              irwrite,
  output logic              iord,
  output logic              branch,
  output logic              jump,
  output logic              memread,
  output logic              memtoreg,
  output logic              memwrite,
  output logic              alusrc,
  output logic              regwrite,
  output logic [ALUOPW-1:0] aluop,
  output logic [2:0]        state,
  output logic              retire,
  output logic [CNTW-1:0]   instret,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  state_t          r_state;
  state_t          w_state_next;
  logic [CNTW-1:0] r_instret;
  logic [6:0]      w_opcode;

  assign w_opcode = instruction[6:0];

  generate
    if (IW > 7) begin : g_upper
      logic w_unused_upper;
      assign w_unused_upper = ^instruction[IW-1:7];
    end
  endgenerate

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_state_next;
      if (retire) r_instret <= r_instret + CNTW'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    pcwrite  = 1'b0;
    irwrite  = 1'b0;
    iord     = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    memread  = 1'b0;
    memtoreg = 1'b0;
    memwrite = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    aluop    = '0;
    retire   = 1'b0;
    illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        memread = 1'b1;
        if (memready) begin
          irwrite      = 1'b1;
          pcwrite      = 1'b1;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_opcode)
          OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JALR: w_state_next = S_EXEC;
`ifdef MULTICYCLE_CONTROL_TRAP_EN
          default: w_state_next = S_TRAP;
`else
          default: w_state_next = S_FETCH;
`endif
        endcase
      end
      S_EXEC: begin
        w_state_next = S_FETCH;
        case (w_opcode)
          OP_R: begin
            aluop        = ALUOPW'(3'b001);
            w_state_next = S_WB;
          end
          OP_I: begin
            aluop        = ALUOPW'(3'b010);
            alusrc       = 1'b1;
            w_state_next = S_WB;
          end
          OP_LD, OP_ST: begin
            alusrc       = 1'b1;
            w_state_next = S_MEM;
          end
          OP_BR: begin
            aluop  = ALUOPW'(3'b011);
            branch = 1'b1;
            retire = 1'b1;
          end
          OP_JALR: begin
            alusrc   = 1'b1;
            jump     = 1'b1;
            pcwrite  = 1'b1;
            regwrite = 1'b1;
            retire   = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        iord     = 1'b1;
        memread  = (w_opcode == OP_LD);
        memwrite = (w_opcode == OP_ST);
        if (memready) begin
          // Stores complete here; loads still need the writeback cycle.
          if (w_opcode == OP_ST) begin
            retire       = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end
      end
      S_WB: begin
        regwrite     = 1'b1;
        memtoreg     = (w_opcode == OP_LD);
        retire       = 1'b1;
        w_state_next = S_FETCH;
      end
`ifdef MULTICYCLE_CONTROL_TRAP_EN
      S_TRAP: begin
        illegal = 1'b1;
      end
`endif
      default: w_state_next = S_FETCH;
    endcase
    // Reset forces every output quiet without waiting for a clock edge.
    if (!rstn) begin
      pcwrite  = 1'b0;
      irwrite  = 1'b0;
      iord     = 1'b0;
      branch   = 1'b0;
      jump     = 1'b0;
      memread  = 1'b0;
      memtoreg = 1'b0;
      memwrite = 1'b0;
      alusrc   = 1'b0;
      regwrite = 1'b0;
      aluop    = '0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

  assign state   = r_state;
  assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; a second instance with CNTW=2 checks counter wrap.
module tb_multicycle_control;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic        memready = 1'b0;

  logic        pcwrite, irwrite, iord, branch, jump, memread, memtoreg, memwrite, alusrc, regwrite;
  logic [2:0]  aluop, state;
  logic        retire, illegal;
  logic [15:0] instret;

  logic        d2_pcwrite, d2_irwrite, d2_iord, d2_branch, d2_jump, d2_memread, d2_memtoreg;
  logic        d2_memwrite, d2_alusrc, d2_regwrite, d2_retire, d2_illegal;
  logic [2:0]  d2_aluop, d2_state;
  logic [1:0]  d2_instret;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control #(.IW(32), .ALUOPW(3), .CNTW(16)) dut (
    .clk(clk), .rstn(rstn), .instruction(instruction), .memready(memready),
    .pcwrite(pcwrite), .irwrite(irwrite), .iord(iord), .branch(branch), .jump(jump),
    .memread(memread), .memtoreg(memtoreg), .memwrite(memwrite), .alusrc(alusrc),
    .regwrite(regwrite), .aluop(aluop), .state(state), .retire(retire),
    .instret(instret), .illegal(illegal)
  );

  multicycle_control #(.IW(32), .ALUOPW(3), .CNTW(2)) dut2 (
    .clk(clk), .rstn(rstn), .instruction(instruction), .memready(memready),
    .pcwrite(d2_pcwrite), .irwrite(d2_irwrite), .iord(d2_iord), .branch(d2_branch), .jump(d2_jump),
    .memread(d2_memread), .memtoreg(d2_memtoreg), .memwrite(d2_memwrite), .alusrc(d2_alusrc),
    .regwrite(d2_regwrite), .aluop(d2_aluop), .state(d2_state), .retire(d2_retire),
    .instret(d2_instret), .illegal(d2_illegal)
  );

  // {state, pcwrite, irwrite, iord, branch, jump, memread, memtoreg, memwrite, alusrc, regwrite, aluop, retire}
  wire [16:0] obs = {state, pcwrite, irwrite, iord, branch, jump, memread, memtoreg,
                     memwrite, alusrc, regwrite, aluop, retire};
  wire [17:0] d2_obs = {d2_state, d2_pcwrite, d2_irwrite, d2_iord, d2_branch, d2_jump, d2_memread,
                        d2_memtoreg, d2_memwrite, d2_alusrc, d2_regwrite, d2_aluop, d2_retire, d2_illegal};

  localparam logic [16:0] E_FETCH  = {3'd0, 10'b1100010000, 3'b000, 1'b0};
  localparam logic [16:0] E_DECODE = {3'd1, 10'b0000000000, 3'b000, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #12;
    if ({obs, instret, illegal} !== 34'h0) begin
      $display("FAIL reset_hold obs=%h instret=%0d illegal=%b required all zero", obs, instret, illegal);
      n_err++;
    end
    n_cmp++;
    release_reset();
  endtask

  task automatic test_rtype();
    logic [16:0] ev [0:3];
    ev = '{E_FETCH, E_DECODE, {3'd2, 10'b0000000000, 3'b001, 1'b0}, {3'd4, 10'b0000000001, 3'b000, 1'b1}};
    instruction = 32'h0000_0033;
    for (int i = 0; i < 4; i++) begin
      memready = 1'b1;
      #1;
      if (obs !== ev[i]) begin
        $display("FAIL rtype cyc%0d got=%h required=%h", i, obs, ev[i]);
        n_err++;
      end
      n_cmp++;
      tick();
    end
    if (state !== 3'd0 || instret !== 16'd1) begin
      $display("FAIL rtype_end state=%0d instret=%0d required 0/1", state, instret);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_load_stall();
    logic [16:0] ev [0:7];
    logic        mr [0:7];
    ev = '{E_FETCH, E_DECODE, {3'd2, 10'b0000000010, 3'b000, 1'b0},
           {3'd3, 10'b0010010000, 3'b000, 1'b0}, {3'd3, 10'b0010010000, 3'b000, 1'b0},
           {3'd3, 10'b0010010000, 3'b000, 1'b0}, {3'd3, 10'b0010010000, 3'b000, 1'b0},
           {3'd4, 10'b0000001001, 3'b000, 1'b1}};
    mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    instruction = 32'h0000_0003;
    for (int i = 0; i < 8; i++) begin
      memready = mr[i];
      #1;
      if (obs !== ev[i]) begin
        $display("FAIL load cyc%0d got=%h required=%h", i, obs, ev[i]);
        n_err++;
      end
      n_cmp++;
      tick();
    end
    if (state !== 3'd0 || instret !== 16'd2) begin
      $display("FAIL load_end state=%0d instret=%0d required 0/2", state, instret);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_store();
    logic [16:0] ev [0:3];
    ev = '{E_FETCH, E_DECODE, {3'd2, 10'b0000000010, 3'b000, 1'b0}, {3'd3, 10'b0010000100, 3'b000, 1'b1}};
    instruction = 32'h0000_0023;
    for (int i = 0; i < 4; i++) begin
      memready = 1'b1;
      #1;
      if (obs !== ev[i]) begin
        $display("FAIL store cyc%0d got=%h required=%h", i, obs, ev[i]);
        n_err++;
      end
      n_cmp++;
      tick();
    end
    if (state !== 3'd0 || instret !== 16'd3) begin
      $display("FAIL store_end state=%0d instret=%0d required 0/3", state, instret);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_jalr_branch();
    logic [16:0] ev [0:5];
    logic [31:0] ins [0:5];
    ev = '{E_FETCH, E_DECODE, {3'd2, 10'b1000100011, 3'b000, 1'b1},
           E_FETCH, E_DECODE, {3'd2, 10'b0001000000, 3'b011, 1'b1}};
    ins = '{32'h67, 32'h67, 32'h67, 32'h63, 32'h63, 32'h63};
    for (int i = 0; i < 6; i++) begin
      instruction = ins[i];
      memready = 1'b1;
      #1;
      if (obs !== ev[i]) begin
        $display("FAIL jalr_branch cyc%0d got=%h required=%h", i, obs, ev[i]);
        n_err++;
      end
      n_cmp++;
      tick();
    end
    if (state !== 3'd0 || instret !== 16'd5) begin
      $display("FAIL jalr_branch_end state=%0d instret=%0d required 0/5", state, instret);
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_mem();
    instruction = 32'h0000_0003;
    memready = 1'b1;
    tick();
    memready = 1'b0;
    tick();
    tick();
    #1;
    if (state !== 3'd3) begin
      $display("FAIL midmem_enter state=%0d required 3", state);
      n_err++;
    end
    n_cmp++;
    rstn = 1'b0;
    #1;
    if ({obs, instret, illegal} !== 34'h0) begin
      $display("FAIL midmem_reset obs=%h instret=%0d illegal=%b required all zero", obs, instret, illegal);
      n_err++;
    end
    n_cmp++;
    tick();
    release_reset();
  endtask

  task automatic test_wrap();
    instruction = 32'h0000_0033;
    memready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (4) tick();
      if (k == 2 && d2_instret !== 2'd3) begin
        $display("FAIL wrap_pre d2_instret=%0d required 3", d2_instret);
        n_err++;
      end
      if (k == 2) n_cmp++;
    end
    #1;
    if (d2_instret !== 2'd0 || instret !== 16'd4) begin
      $display("FAIL wrap d2_instret=%0d instret=%0d required 0/4", d2_instret, instret);
      n_err++;
    end
    n_cmp++;
    if (d2_obs !== {E_FETCH, 1'b0}) begin
      $display("FAIL wrap_d2_fetch got=%h required=%h", d2_obs, {E_FETCH, 1'b0});
      n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_illegal();
    instruction = 32'h0000_007F;
    memready = 1'b1;
    #1;
    if (obs !== E_FETCH) begin
      $display("FAIL illegal_fetch got=%h required=%h", obs, E_FETCH);
      n_err++;
    end
    n_cmp++;
    tick();
    if (obs !== E_DECODE) begin
      $display("FAIL illegal_decode got=%h required=%h", obs, E_DECODE);
      n_err++;
    end
    n_cmp++;
    tick();
`ifdef MULTICYCLE_CONTROL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      if (obs !== {3'd5, 14'h0} || illegal !== 1'b1 || instret !== 16'd4) begin
        $display("FAIL trap cyc%0d obs=%h illegal=%b instret=%0d required %h/1/4",
                 i, obs, illegal, instret, {3'd5, 14'h0});
        n_err++;
      end
      n_cmp++;
      tick();
    end
    rstn = 1'b0;
    #1;
    if (state !== 3'd0 || illegal !== 1'b0 || instret !== 16'd0) begin
      $display("FAIL trap_reset state=%0d illegal=%b instret=%0d required 0/0/0", state, illegal, instret);
      n_err++;
    end
    n_cmp++;
    tick();
    release_reset();
`else
    if (state !== 3'd0 || instret !== 16'd4 || illegal !== 1'b0) begin
      $display("FAIL illegal_skip state=%0d instret=%0d illegal=%b required 0/4/0", state, instret, illegal);
      n_err++;
    end
    n_cmp++;
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rtype();
    test_load_stall();
    test_store();
    test_jalr_branch();
    test_reset_mid_mem();
    test_wrap();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
